// File: rtl/trade_event_fifo.sv
// -----------------------------------------------------------------------------
// trade_event_fifo
//
// Purpose:
//   Sits behind the ITCH byte parser. Captures each parsed 'P' (trade) message
//   on a field_valid pulse, computes notional = price * volume in a single
//   stage register, and queues the resulting record in a first-word-fall-through
//   FIFO with a valid/ready output for the strategy/stats stage. Records that
//   arrive while the FIFO is full (and nothing pops that cycle) are dropped
//   and counted.
//
// Configuration macro:
//   TRADE_FIFO_TS_EN - when defined, a free-running 48-bit cycle counter is
//                      captured with each record and presented on out_ts.
//                      When undefined, out_ts is tied to zero and no
//                      timestamp storage exists.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   CNT_W  width of trade_count / drop_count
//
// Ports:
//   clk           in   single clock, posedge
//   rst_n         in   asynchronous assert, active-low reset
//   field_valid   in   1-cycle pulse: msg_type/order_id/price/volume valid
//   msg_type      in   [7:0]  only 8'h50 ('P') is accepted
//   order_id      in   [63:0]
//   price         in   [31:0] integer $/1e4
//   volume        in   [31:0] shares
//   out_valid     out  head record present
//   out_ready     in   consumer takes the head this cycle
//   out_order_id  out  [63:0] head order_id
//   out_price     out  [31:0] head price
//   out_volume    out  [31:0] head volume
//   out_notional  out  [63:0] head price*volume (unsigned, exact)
//   out_ts        out  [47:0] head capture timestamp (zero when disabled)
//   level         out  [$clog2(DEPTH):0] entries stored
//   trade_count   out  [CNT_W-1:0] records written, saturating
//   drop_count    out  [CNT_W-1:0] records dropped on full, saturating
// -----------------------------------------------------------------------------
module trade_event_fifo #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     field_valid,
    input  logic [7:0]               msg_type,
    input  logic [63:0]              order_id,
    input  logic [31:0]              price,
    input  logic [31:0]              volume,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [63:0]              out_order_id,
    output logic [31:0]              out_price,
    output logic [31:0]              out_volume,
    output logic [63:0]              out_notional,
    output logic [47:0]              out_ts,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         trade_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [7:0] MSG_TRADE = 8'h50;

`ifdef TRADE_FIFO_TS_EN
    localparam int REC_W = 64 + 32 + 32 + 64 + 48;
`else
    localparam int REC_W = 64 + 32 + 32 + 64;
`endif

    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Stage register S: one cycle between the parser pulse and the FIFO
    // write, which gives the multiplier a full cycle to itself.
    // ------------------------------------------------------------------
    logic              r_s_valid;
    logic [REC_W-1:0]  r_s_rec;
    logic [REC_W-1:0]  w_in_rec;
    logic              w_accept;
    logic [63:0]       w_notional;

    assign w_accept   = field_valid && (msg_type == MSG_TRADE);
    assign w_notional = 64'(price) * 64'(volume);

`ifdef TRADE_FIFO_TS_EN
    // Free-running cycle counter; wraps naturally at 2^48.
    logic [47:0] r_ts;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts <= 48'h0;
        end else begin
            r_ts <= r_ts + 48'd1;
        end
    end

    assign w_in_rec = {order_id, price, volume, w_notional, r_ts};
`else
    assign w_in_rec = {order_id, price, volume, w_notional};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_valid <= 1'b0;
            r_s_rec   <= '0;
        end else begin
            // Refilled every edge so back-to-back pulses never collide; fields
            // are only loaded for accepted trades to avoid needless toggling.
            r_s_valid <= w_accept;
            if (w_accept) begin
                r_s_rec <= w_in_rec;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers: one extra MSB distinguishes full from empty.
    // ------------------------------------------------------------------
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic           w_empty;
    logic           w_full;
    logic           w_pop;
    logic           w_wr_en;
    logic           w_drop;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && out_ready;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO
    // still accepts the push when the consumer is draining.
    assign w_wr_en = r_s_valid && (!w_full || w_pop);
    assign w_drop  = r_s_valid && w_full && !w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage: each entry is its own register so that reset can clear it
    // and the head can be read combinationally (first-word fall-through).
    // ------------------------------------------------------------------
    logic [REC_W-1:0] w_entries [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [REC_W-1:0] r_entry;
            logic             w_sel;

            assign w_sel = w_wr_en && (r_wr_ptr[AW-1:0] == AW'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_entry <= '0;
                end else if (w_sel) begin
                    r_entry <= r_s_rec;
                end
            end

            assign w_entries[gi] = r_entry;
        end
    endgenerate

    logic [REC_W-1:0] w_head;

    assign w_head = w_entries[r_rd_ptr[AW-1:0]];

    assign out_valid    = !w_empty;
    assign out_order_id = w_head[REC_W-1     -: 64];
    assign out_price    = w_head[REC_W-64-1  -: 32];
    assign out_volume   = w_head[REC_W-96-1  -: 32];
    assign out_notional = w_head[REC_W-128-1 -: 64];
`ifdef TRADE_FIFO_TS_EN
    assign out_ts       = w_head[47:0];
`else
    assign out_ts       = 48'h0;
`endif

    assign level = r_wr_ptr - r_rd_ptr;

    // ------------------------------------------------------------------
    // Saturating statistics counters.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] r_trade_count;
    logic [CNT_W-1:0] r_drop_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trade_count <= '0;
            r_drop_count  <= '0;
        end else begin
            if (w_wr_en && (r_trade_count != '1)) begin
                r_trade_count <= r_trade_count + CNT_ONE;
            end
            if (w_drop && (r_drop_count != '1)) begin
                r_drop_count <= r_drop_count + CNT_ONE;
            end
        end
    end

    assign trade_count = r_trade_count;
    assign drop_count  = r_drop_count;

endmodule

// File: tb/tb_trade_event_fifo.sv
// -----------------------------------------------------------------------------
// tb_trade_event_fifo
//
// Self-checking bench for trade_event_fifo. Stimulus is driven on the falling
// edge, outputs are sampled on the falling edge. Every accepted trade that is
// expected to be stored is pushed onto a scoreboard queue when it is driven
// and compared against the FIFO head when popped.
// -----------------------------------------------------------------------------
module tb_trade_event_fifo;

    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   field_valid;
    logic [7:0]             msg_type;
    logic [63:0]            order_id;
    logic [31:0]            price;
    logic [31:0]            volume;
    logic                   out_valid;
    logic                   out_ready;
    logic [63:0]            out_order_id;
    logic [31:0]            out_price;
    logic [31:0]            out_volume;
    logic [63:0]            out_notional;
    logic [47:0]            out_ts;
    logic [$clog2(DEPTH):0] level;
    logic [CNT_W-1:0]       trade_count;
    logic [CNT_W-1:0]       drop_count;

    always #5 clk = ~clk;

    trade_event_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .field_valid  (field_valid),
        .msg_type     (msg_type),
        .order_id     (order_id),
        .price        (price),
        .volume       (volume),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_order_id (out_order_id),
        .out_price    (out_price),
        .out_volume   (out_volume),
        .out_notional (out_notional),
        .out_ts       (out_ts),
        .level        (level),
        .trade_count  (trade_count),
        .drop_count   (drop_count)
    );

    typedef struct {
        logic [63:0] oid;
        logic [31:0] price;
        logic [31:0] vol;
        logic [63:0] notional;
        logic [47:0] ts;
    } rec_t;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Cycles elapsed since reset release: the timestamp a record should carry
    // is the count of rising edges seen before its capture edge.
    logic [47:0] tb_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 48'h0;
        else        tb_cyc <= tb_cyc + 48'd1;
    end

    // Tasks below start and end just after a falling edge.
    task automatic do_reset();
        rst_n       = 1'b0;
        field_valid = 1'b0;
        out_ready   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic drive(input logic [7:0] t, input logic [63:0] oid,
                         input logic [31:0] p, input logic [31:0] v,
                         input bit expect_store);
        rec_t r;
        field_valid = 1'b1;
        msg_type    = t;
        order_id    = oid;
        price       = p;
        volume      = v;
        if (expect_store) begin
            r.oid      = oid;
            r.price    = p;
            r.vol      = v;
            r.notional = 64'(p) * 64'(v);
`ifdef TRADE_FIFO_TS_EN
            r.ts       = tb_cyc;
`else
            r.ts       = 48'h0;
`endif
            exp_q.push_back(r);
        end
        @(negedge clk);
        field_valid = 1'b0;
    endtask

    task automatic pop_check(input string tag);
        rec_t e;
        checks++;
        if (out_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s pop_ready: out_valid=%b expected 1, scoreboard size=%0d",
                     tag, out_valid, exp_q.size());
        end else begin
            e = exp_q.pop_front();
            checks++;
            if ({out_order_id, out_price, out_volume, out_notional, out_ts} !==
                {e.oid, e.price, e.vol, e.notional, e.ts}) begin
                errors++;
                $display("FAIL %s head: got oid=%h price=%0d vol=%0d notional=%0d ts=%0d expected oid=%h price=%0d vol=%0d notional=%0d ts=%0d",
                         tag, out_order_id, out_price, out_volume, out_notional, out_ts,
                         e.oid, e.price, e.vol, e.notional, e.ts);
            end else begin
                $display("pop %s: oid=%h price=%0d vol=%0d notional=%0d ts=%0d",
                         tag, out_order_id, out_price, out_volume, out_notional, out_ts);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if ({out_valid, level, trade_count, drop_count} !== '0) begin
            errors++;
            $display("FAIL reset_status: got valid=%b level=%0d trades=%0d drops=%0d expected all 0",
                     out_valid, level, trade_count, drop_count);
        end
        checks++;
        if ({out_order_id, out_price, out_volume, out_notional, out_ts} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got oid=%h price=%0d vol=%0d notional=%0d ts=%0d expected 0",
                     out_order_id, out_price, out_volume, out_notional, out_ts);
        end
        $display("reset: valid=%b level=%0d", out_valid, level);
    endtask

    task automatic test_single();
        do_reset();
        drive(8'h50, 64'h1122334455667788, 32'd1500000, 32'd200, 1'b1);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early: out_valid=%b expected 0 one cycle after pulse", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || level !== 5'd1) begin
            errors++;
            $display("FAIL single_latency: valid=%b level=%0d expected 1/1", out_valid, level);
        end
        checks++;
        if (out_notional !== 64'd300000000 || trade_count !== 32'd1) begin
            errors++;
            $display("FAIL single_notional: notional=%0d trades=%0d expected 300000000/1",
                     out_notional, trade_count);
        end
        pop_check("single");
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL single_after_pop: valid=%b level=%0d expected 0/0", out_valid, level);
        end
    endtask

    task automatic test_reject();
        do_reset();
        drive(8'h41, 64'hDEAD, 32'd100, 32'd5, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0 || trade_count !== 32'd0 || drop_count !== 32'd0) begin
            errors++;
            $display("FAIL reject_type: valid=%b level=%0d trades=%0d drops=%0d expected all 0",
                     out_valid, level, trade_count, drop_count);
        end
        $display("reject: msg_type=41 level=%0d trades=%0d", level, trade_count);
    endtask

    task automatic test_overflow();
        do_reset();
        for (int v = 1; v <= DEPTH + 3; v++) begin
            drive(8'h50, 64'hA000 + 64'(v), 32'hF000_0000 + 32'(v * 977), 32'(v), v <= DEPTH);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (level !== 5'd16 || drop_count !== 32'd3 || trade_count !== 32'd16) begin
            errors++;
            $display("FAIL overflow_counts: level=%0d drops=%0d trades=%0d expected 16/3/16",
                     level, drop_count, trade_count);
        end
        // Head must hold while the consumer stalls.
        repeat (3) @(negedge clk);
        checks++;
        if (out_volume !== 32'd1) begin
            errors++;
            $display("FAIL overflow_hold: head volume=%0d expected 1", out_volume);
        end
        for (int i = 0; i < DEPTH; i++) pop_check("overflow");
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL overflow_drained: valid=%b level=%0d expected 0/0", out_valid, level);
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int v = 1; v <= DEPTH; v++) begin
            drive(8'h50, 64'hB000 + 64'(v), 32'd5000 + 32'(v), 32'(v * 3), 1'b1);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (level !== 5'd16) begin
            errors++;
            $display("FAIL fullpop_fill: level=%0d expected 16", level);
        end
        // New trade reaches the FIFO on the same edge the consumer pops.
        drive(8'h50, 64'hBEEF, 32'd777, 32'd99, 1'b1);
        pop_check("fullpop");
        checks++;
        if (level !== 5'd16 || drop_count !== 32'd0 || trade_count !== 32'd17) begin
            errors++;
            $display("FAIL fullpop_accept: level=%0d drops=%0d trades=%0d expected 16/0/17",
                     level, drop_count, trade_count);
        end
        for (int i = 0; i < DEPTH; i++) pop_check("fullpop_drain");
        checks++;
        if (out_valid !== 1'b0 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL fullpop_drained: valid=%b leftover=%0d expected 0/0", out_valid, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive(8'h50, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(8'h50, {$urandom, $urandom}, $urandom, $urandom, 1'b1);
        end
        drive(8'h45, 64'h1, 32'd1, 32'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(8'h50, {$urandom, $urandom}, $urandom, $urandom, 1'b1);
        end
        @(negedge clk);
        checks++;
        if (level !== 5'd7 || trade_count !== 32'd7) begin
            errors++;
            $display("FAIL b2b_level: level=%0d trades=%0d expected 7/7", level, trade_count);
        end
        while (exp_q.size() != 0) pop_check("b2b");
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            drive(8'h50, 64'hC000 + 64'(v), 32'd42, 32'(v), 1'b1);
        end
        @(negedge clk);
        checks++;
        if (level !== 5'd5) begin
            errors++;
            $display("FAIL midrst_fill: level=%0d expected 5", level);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || level !== 5'd0) begin
            errors++;
            $display("FAIL midrst_async: valid=%b level=%0d expected 0/0 during reset", out_valid, level);
        end
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        drive(8'h50, 64'hD00D, 32'd250, 32'd8, 1'b1);
        @(negedge clk);
        checks++;
        if (level !== 5'd1 || trade_count !== 32'd1) begin
            errors++;
            $display("FAIL midrst_after: level=%0d trades=%0d expected 1/1", level, trade_count);
        end
        pop_check("midrst");
    endtask

    initial begin
        rst_n       = 1'b0;
        field_valid = 1'b0;
        msg_type    = 8'h0;
        order_id    = 64'h0;
        price       = 32'h0;
        volume      = 32'h0;
        out_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_single();
        test_reject();
        test_overflow();
        test_full_pop();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
